// File: rtl/bloom_pkg.sv
// Shared types and sizing helpers for the Bloom filter insert path.
package bloom_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  // Lane index width: ceil(log2(n)), never less than one bit.
  function automatic int unsigned lane_idx_w(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/bloom_dup_mask.sv
// Flags every hash lane whose address repeats an earlier lane of the same key.
module bloom_dup_mask
  import bloom_pkg::*;
#(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned HASH_CNT = 3
) (
  input  logic [HASH_CNT*ADDR_W-1:0] hash_data,
  output logic [HASH_CNT-1:0]        dup_mask
);

  // Lane 0 is never marked, so each key keeps at least one write.
  always_comb begin
    dup_mask = '0;
    for (int k = 1; k < HASH_CNT; k++) begin
      for (int j = 0; j < k; j++) begin
        if (hash_data[k*ADDR_W +: ADDR_W] == hash_data[j*ADDR_W +: ADDR_W]) begin
          dup_mask[k] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bloom_insert_seq.sv
// Turns one key of HASH_CNT hash addresses into per-lane Avalon-MM set writes.
// Optional BLOOM_INSERT_DEDUP_EN skips lanes that repeat an earlier lane.
module bloom_insert_seq
  import bloom_pkg::*;
#(
  parameter int unsigned          AMM_ADDR_W = 5,
  parameter int unsigned          AMM_DATA_W = 5,
  parameter int unsigned          HASH_CNT   = 3,
  parameter logic [AMM_DATA_W-1:0] SET_DATA  = '1
) (
  input  logic                           clk_i,
  input  logic                           srst_i,
  input  logic                           hash_valid_i,
  output logic                           hash_ready_o,
  input  logic [HASH_CNT*AMM_ADDR_W-1:0] hash_data_i,
  input  logic                           clr_done_i,
  output logic                           busy_o,
  output logic [AMM_ADDR_W-1:0]          amm_master_address_o,
  output logic                           amm_master_write_o,
  output logic [AMM_DATA_W-1:0]          amm_master_writedata_o
);

  localparam int unsigned IDX_W   = lane_idx_w(HASH_CNT);
  localparam int unsigned LANES_W = HASH_CNT * AMM_ADDR_W;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d, nxt_idx;
  logic [LANES_W-1:0]      lanes_q, lanes_d;
  logic [AMM_ADDR_W-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic [AMM_DATA_W-1:0]   wdata_q;
  logic                    last_c;
  logic                    ready_c;
  logic                    accept_c;
  int unsigned             nxt_base;

`ifdef BLOOM_INSERT_DEDUP_EN
  logic [HASH_CNT-1:0] mask_q, mask_d, mask_c;

  bloom_dup_mask #(
    .ADDR_W   (AMM_ADDR_W),
    .HASH_CNT (HASH_CNT)
  ) u_dup_mask (
    .hash_data (hash_data_i),
    .dup_mask  (mask_c)
  );

  // Next lane is the lowest unmarked lane above the current one.
  always_comb begin
    nxt_idx = idx_q;
    last_c  = 1'b1;
    for (int k = HASH_CNT - 1; k >= 0; k--) begin
      if ((k > int'(idx_q)) && !mask_q[k]) begin
        nxt_idx = IDX_W'(k);
        last_c  = 1'b0;
      end
    end
  end
`else
  assign last_c  = (idx_q == IDX_W'(HASH_CNT - 1));
  assign nxt_idx = idx_q + IDX_W'(1);
`endif

  // Ready is forced low during reset and whenever a clear sweep owns memory.
  assign ready_c  = !srst_i && clr_done_i && ((state_q == IDLE) || last_c);
  assign accept_c = hash_valid_i && ready_c;
  assign nxt_base = 32'(nxt_idx) * AMM_ADDR_W;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lanes_d = lanes_q;
    addr_d  = addr_q;
    write_d = 1'b0;
`ifdef BLOOM_INSERT_DEDUP_EN
    mask_d  = mask_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = WRITE;
          idx_d   = '0;
          lanes_d = hash_data_i;
          addr_d  = hash_data_i[AMM_ADDR_W-1:0];
          write_d = 1'b1;
`ifdef BLOOM_INSERT_DEDUP_EN
          mask_d  = mask_c;
`endif
        end
      end
      WRITE: begin
        if (!clr_done_i) begin
          // Clear sweep wipes memory, so the rest of the key is dropped.
          state_d = IDLE;
        end else if (!last_c) begin
          idx_d   = nxt_idx;
          addr_d  = lanes_q[nxt_base +: AMM_ADDR_W];
          write_d = 1'b1;
        end else if (accept_c) begin
          idx_d   = '0;
          lanes_d = hash_data_i;
          addr_d  = hash_data_i[AMM_ADDR_W-1:0];
          write_d = 1'b1;
`ifdef BLOOM_INSERT_DEDUP_EN
          mask_d  = mask_c;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      lanes_q <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= SET_DATA;
`ifdef BLOOM_INSERT_DEDUP_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lanes_q <= lanes_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= SET_DATA;
`ifdef BLOOM_INSERT_DEDUP_EN
      mask_q  <= mask_d;
`endif
    end
  end

  assign hash_ready_o           = ready_c;
  assign busy_o                 = (state_q == WRITE);
  assign amm_master_address_o   = addr_q;
  assign amm_master_write_o     = write_q;
  assign amm_master_writedata_o = wdata_q;

endmodule

// File: tb/tb_bloom_insert_seq.sv
// Directed scoreboard bench for bloom_insert_seq (HASH_CNT=3 and HASH_CNT=1 instances).
module tb_bloom_insert_seq;

  localparam logic [4:0] SET = 5'h1f;

  logic        clk;
  logic        srst;
  logic        clr_done;
  logic        valid0, ready0, busy0, wr0;
  logic [14:0] data0;
  logic [4:0]  addr0, wd0;
  logic        valid1, ready1, busy1, wr1;
  logic [4:0]  data1;
  logic [4:0]  addr1, wd1;

  int total = 0;
  int bad   = 0;
  logic [4:0] q0[$];
  logic [4:0] q1[$];
  logic [4:0] e0, e1;

  bloom_insert_seq #(.HASH_CNT(3)) u0 (
    .clk_i                  (clk),
    .srst_i                 (srst),
    .hash_valid_i           (valid0),
    .hash_ready_o           (ready0),
    .hash_data_i            (data0),
    .clr_done_i             (clr_done),
    .busy_o                 (busy0),
    .amm_master_address_o   (addr0),
    .amm_master_write_o     (wr0),
    .amm_master_writedata_o (wd0)
  );

  bloom_insert_seq #(.HASH_CNT(1)) u1 (
    .clk_i                  (clk),
    .srst_i                 (srst),
    .hash_valid_i           (valid1),
    .hash_ready_o           (ready1),
    .hash_data_i            (data1),
    .clr_done_i             (clr_done),
    .busy_o                 (busy1),
    .amm_master_address_o   (addr1),
    .amm_master_write_o     (wr1),
    .amm_master_writedata_o (wd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Writes only take effect while the clear stage passes them through.
  always @(negedge clk) begin
    if (wr0 === 1'b1 && clr_done === 1'b1) begin
      total++;
      if (q0.size() == 0) begin
        bad++;
        $display("FAIL u0_write unexpected addr=%0d", addr0);
      end else begin
        e0 = q0.pop_front();
        if (addr0 !== e0 || wd0 !== SET) begin
          bad++;
          $display("FAIL u0_write got addr=%0d data=%0h want addr=%0d data=%0h", addr0, wd0, e0, SET);
        end
      end
    end
    if (wr1 === 1'b1 && clr_done === 1'b1) begin
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL u1_write unexpected addr=%0d", addr1);
      end else begin
        e1 = q1.pop_front();
        if (addr1 !== e1 || wd1 !== SET) begin
          bad++;
          $display("FAIL u1_write got addr=%0d data=%0h want addr=%0d data=%0h", addr1, wd1, e1, SET);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    srst = 1'b1; clr_done = 1'b1;
    valid0 = 1'b0; data0 = '0; valid1 = 1'b0; data1 = '0;
    tick(); tick();
    #1;
    chk("ready_in_reset", 32'(ready0), 32'd0);
    chk("ready1_in_reset", 32'(ready1), 32'd0);
    tick();
    srst = 1'b0;
    #1;
    chk("rst_write", 32'(wr0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_addr", 32'(addr0), 32'd0);
    chk("rst_wdata", 32'(wd0), 32'(SET));
    chk("rst_ready", 32'(ready0), 32'd1);

    // Single key {5,9,17}
    tick();
    valid0 = 1'b1; data0 = {5'd17, 5'd9, 5'd5};
    q0.push_back(5'd5); q0.push_back(5'd9); q0.push_back(5'd17);
    #1 chk("single_ready_c0", 32'(ready0), 32'd1);
    tick(); valid0 = 1'b0;
    #1 chk("single_busy_c1", 32'(busy0), 32'd1);
    chk("single_ready_c1", 32'(ready0), 32'd0);
    tick();
    #1 chk("single_busy_c2", 32'(busy0), 32'd1);
    chk("single_ready_c2", 32'(ready0), 32'd0);
    tick();
    #1 chk("single_busy_c3", 32'(busy0), 32'd1);
    chk("single_ready_c3", 32'(ready0), 32'd1);
    tick();
    #1 chk("single_busy_c4", 32'(busy0), 32'd0);
    chk("single_write_c4", 32'(wr0), 32'd0);

    // Back-to-back keys {6,7,8} then {12,13,14}
    tick();
    valid0 = 1'b1; data0 = {5'd8, 5'd7, 5'd6};
    q0.push_back(5'd6); q0.push_back(5'd7); q0.push_back(5'd8);
    #1 chk("b2b_ready_c0", 32'(ready0), 32'd1);
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) begin
        data0 = {5'd14, 5'd13, 5'd12};
        q0.push_back(5'd12); q0.push_back(5'd13); q0.push_back(5'd14);
      end
      if (c == 4) valid0 = 1'b0;
      #1 chk($sformatf("b2b_write_c%0d", c), 32'(wr0), 32'd1);
      if (c < 6) chk($sformatf("b2b_ready_c%0d", c), 32'(ready0), (c == 3) ? 32'd1 : 32'd0);
    end
    tick();
    #1 chk("b2b_idle", 32'(busy0), 32'd0);

    // Clear preemption on second write of {10,11,12}
    tick();
    valid0 = 1'b1; data0 = {5'd12, 5'd11, 5'd10};
    q0.push_back(5'd10);
    #1 chk("pre_ready_c0", 32'(ready0), 32'd1);
    tick(); valid0 = 1'b0;
    #1 chk("pre_write_c1", 32'(wr0), 32'd1);
    tick(); clr_done = 1'b0;
    #1 chk("pre_ready_c2", 32'(ready0), 32'd0);
    tick();
    valid0 = 1'b1; data0 = {5'd22, 5'd21, 5'd20};
    #1 chk("pre_write_c3", 32'(wr0), 32'd0);
    chk("pre_busy_c3", 32'(busy0), 32'd0);
    chk("pre_ready_c3", 32'(ready0), 32'd0);
    tick();
    #1 chk("pre_busy_c4", 32'(busy0), 32'd0);
    chk("pre_ready_c4", 32'(ready0), 32'd0);
    tick(); clr_done = 1'b1;
    q0.push_back(5'd20); q0.push_back(5'd21); q0.push_back(5'd22);
    #1 chk("pre_ready_c5", 32'(ready0), 32'd1);
    tick(); valid0 = 1'b0;
    tick(); tick(); tick();
    #1 chk("pre_done_busy", 32'(busy0), 32'd0);

    // Duplicate lanes {4,4,7}
    tick();
    valid0 = 1'b1; data0 = {5'd7, 5'd4, 5'd4};
`ifdef BLOOM_INSERT_DEDUP_EN
    q0.push_back(5'd4); q0.push_back(5'd7);
`else
    q0.push_back(5'd4); q0.push_back(5'd4); q0.push_back(5'd7);
`endif
    tick(); valid0 = 1'b0;
    #1 chk("dup_ready_c1", 32'(ready0), 32'd0);
    tick();
`ifdef BLOOM_INSERT_DEDUP_EN
    #1 chk("dup_ready_c2", 32'(ready0), 32'd1);
    tick();
    #1 chk("dup_busy_c3", 32'(busy0), 32'd0);
`else
    #1 chk("dup_ready_c2", 32'(ready0), 32'd0);
    tick();
    #1 chk("dup_ready_c3", 32'(ready0), 32'd1);
    chk("dup_busy_c3", 32'(busy0), 32'd1);
    tick();
    #1 chk("dup_busy_c4", 32'(busy0), 32'd0);
`endif

    // Reset mid-key {1,2,3}: lanes 1 and 2 issue, lane 3 never does
    tick();
    valid0 = 1'b1; data0 = {5'd3, 5'd2, 5'd1};
    q0.push_back(5'd1); q0.push_back(5'd2);
    tick(); valid0 = 1'b0;
    tick(); srst = 1'b1;
    #1 chk("srst_ready", 32'(ready0), 32'd0);
    tick(); srst = 1'b0;
    #1 chk("srst_write", 32'(wr0), 32'd0);
    chk("srst_busy", 32'(busy0), 32'd0);
    chk("srst_addr", 32'(addr0), 32'd0);
    tick(); tick(); tick();

    // HASH_CNT=1 streaming of 8 keys
    tick();
    valid1 = 1'b1; data1 = 5'd3;
    q1.push_back(5'd3);
    #1 chk("h1_ready_0", 32'(ready1), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i < 8) begin
        data1 = 5'(i * 7 + 3);
        q1.push_back(5'(i * 7 + 3));
      end else begin
        valid1 = 1'b0;
      end
      #1 chk($sformatf("h1_write_%0d", i), 32'(wr1), 32'd1);
      chk($sformatf("h1_ready_%0d", i), 32'(ready1), 32'd1);
    end
    tick();
    #1 chk("h1_idle_write", 32'(wr1), 32'd0);

    tick(); tick();
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bloom_insert_seq.md
# bloom_insert_seq

Insert sequencer for the Bloom filter bit memory. Accepts one key per valid/ready handshake as HASH_CNT pre-computed hash addresses and turns it into HASH_CNT single-cycle Avalon-MM set writes. It sits directly upstream of the memory-clear stage and drives that stage's slave write port. It watches the clear stage's done flag so that no insert writes are issued while a clear sweep owns the memory.

## Interface
- AMM_ADDR_W, 5: bit-memory address width; also the width of one hash lane.
- AMM_DATA_W, 5: write data width.
- HASH_CNT, 3: hash lanes per key; legal range ≥1.
- SET_DATA, '1: constant written to mark an address as set.

- clk_i  in  1  clock; all logic on rising edge.
- srst_i  in  1  synchronous reset, active-high.
- hash_valid_i  in  1  key hashes valid.
- hash_ready_o  out  1  sequencer can accept a key this cycle.
- hash_data_i  in  HASH_CNT*AMM_ADDR_W  lane k at bits [k*AMM_ADDR_W +: AMM_ADDR_W].
- clr_done_i  in  1  high = clear stage idle and passing writes through.
- busy_o  out  1  key in flight (state WRITE).
- amm_master_address_o  out  AMM_ADDR_W  write address.
- amm_master_write_o  out  1  write strobe.
- amm_master_writedata_o  out  AMM_DATA_W  always SET_DATA.

## Operation
- States: IDLE, WRITE.
- IDLE: hash_ready_o = clr_done_i. On hash_valid_i && hash_ready_o, capture all lanes, set lane index to 0, go to WRITE.
- WRITE: every cycle, issue one write (write = 1, address = current lane) and advance to the next lane to be written.
- After the last lane is written: if a new key is accepted in the same cycle, stay in WRITE with index 0. Otherwise go to IDLE.
- hash_ready_o in WRITE = clr_done_i && (current lane is last). This allows back-to-back keys with no bubble.
- Lanes are written in ascending order, lane 0 first.
- Clear preemption: if clr_done_i is low in any WRITE cycle, drop the key, deassert write, and go to IDLE. Remaining lanes are discarded, because the clear wipes memory anyway. No new key is accepted until clr_done_i returns high.
- Equal lane addresses within a key are written redundantly, unless the configuration feature below is enabled.
- Reset values: state IDLE; hash_ready_o 0 during reset, then equals clr_done_i; busy_o 0; amm_master_write_o 0; amm_master_address_o 0; amm_master_writedata_o SET_DATA.

## Timing
- All AMM outputs are registered.
- The write for lane 0 appears in the cycle after the accepting handshake.
- Key throughput: one key per HASH_CNT cycles. With dedup enabled: one key per count of unique lanes.
- busy_o is high in exactly the cycles in which a key's writes are pending or issuing.
- HASH_CNT = 1: ready is high every cycle that clr_done_i is high, giving one write per cycle.
- srst_i mid-key: the key is discarded, and the next cycle shows reset values.
- Lane index width is $clog2(HASH_CNT), with a minimum of 1. The index never exceeds HASH_CNT-1.

## Configuration
- BLOOM_INSERT_DEDUP_EN defined:
  - At accept time, a duplicate mask is registered. Lane k is marked if it equals any lane j < k.
  - Marked lanes are skipped with no cycle spent. "Last lane" means the highest unmarked lane.
  - Lane 0 is never marked, so every key produces at least one write.
- BLOOM_INSERT_DEDUP_EN undefined:
  - No mask logic is present. Every lane is written, and a key always takes exactly HASH_CNT cycles.

## Structure
- Package bloom_pkg holds:
  - the state enum typedef (IDLE, WRITE);
  - a localparam function for the lane-index width.
- Sub-module bloom_dup_mask: combinational lane-compare producing a HASH_CNT-bit mask. It is instantiated only under BLOOM_INSERT_DEDUP_EN.

## Test plan
- Single key, HASH_CNT=3, lanes {5,9,17}, clr_done_i=1:
  - writes to 5, 9, 17 on cycles 1–3 after accept, data SET_DATA;
  - busy_o high for 3 cycles, then IDLE.
- Two keys presented back-to-back, hash_valid_i held high:
  - six consecutive write cycles with no gap;
  - hash_ready_o high only on cycle 0 and cycle 3.
- clr_done_i driven low on the second write of a key:
  - writes stop that cycle, state goes to IDLE, lane 3 is never written;
  - hash_ready_o stays 0 until clr_done_i rises.
- Lanes {4,4,7}:
  - without the macro, three writes: 4, 4, 7;
  - with BLOOM_INSERT_DEDUP_EN, two writes (4, 7), and ready asserts on the second write.
- srst_i asserted mid-key: the next cycle has write 0, busy_o 0, state IDLE, and the remaining lanes are never written.
- HASH_CNT=1, 8 keys streamed: 8 consecutive writes, ready continuously high.
